uart_baud_gen_frac: RTL



---
 rtl/uart_baud_gen_frac.sv | 118 +++++++++++
 1 files changed

// File: rtl/uart_baud_gen_frac.sv
// Fractional-divisor UART baud tick generator: os/mid/bit enable ticks plus os_phase.
// Latency: registered outputs; first os_tick on the L-th enabled edge after reset/resync.
// Backpressure: none; enable low freezes all state and gates ticks, resync restarts phase.
module uart_baud_gen_frac #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int DEFAULT_BAUD = 9600,
  parameter int OVERSAMPLE   = 16,
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4,
  localparam int PH_W        = $clog2(OVERSAMPLE)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              resync,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic [PH_W-1:0]   os_phase
);

  // Reset divisor derived from the clock and default baud, in 64-bit to avoid overflow
  // of CLK_FREQ * 2^FRAC_W.
  localparam logic [63:0] OS_RATE      = 64'(DEFAULT_BAUD) * 64'(OVERSAMPLE);
  localparam logic [63:0] DEF_INT_FULL = 64'(CLK_FREQ) / OS_RATE;
  localparam logic [63:0] DEF_SCALED   = (64'(CLK_FREQ) << FRAC_W) / OS_RATE;
  localparam logic [DIV_W-1:0]  DEF_INT  = (DEF_INT_FULL < 64'd2) ? DIV_W'(2)
                                                                   : DIV_W'(DEF_INT_FULL);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_SCALED);
  localparam logic [PH_W-1:0]   MID_PHASE = PH_W'(OVERSAMPLE / 2);

  // Shadow divisor: written by div_load, promoted at the next boundary or resync.
  logic [DIV_W-1:0]  sh_int;
  logic [FRAC_W-1:0] sh_frac;

  // Period state: cur_len is the length of the period in progress, so a shadow
  // update mid-period cannot shorten or stretch it.
  logic [DIV_W:0]    cnt;
  logic [DIV_W:0]    cur_len;
  logic [FRAC_W-1:0] acc;

  // Combinational helpers
  logic [DIV_W-1:0]  ld_int;
  logic [DIV_W-1:0]  nxt_int;
  logic [FRAC_W-1:0] nxt_frac;
  logic [FRAC_W-1:0] acc_sum;
  logic              carry;
  logic [DIV_W:0]    nxt_len;
  logic              at_end;
  logic [PH_W-1:0]   phase_inc;

  // Divisor selection with same-cycle load bypass, fractional accumulate and end-of-period detect.
  always_comb begin
    ld_int           = (div_int < DIV_W'(2)) ? DIV_W'(2) : div_int;
    nxt_int          = div_load ? ld_int   : sh_int;
    nxt_frac         = div_load ? div_frac : sh_frac;
    {carry, acc_sum} = {1'b0, acc} + {1'b0, nxt_frac};
    nxt_len          = {1'b0, nxt_int} + {{DIV_W{1'b0}}, carry};
    at_end           = (cnt == (cur_len - 1'b1));
    phase_inc        = os_phase + 1'b1;
  end

  // Shadow divisor capture; independent of enable so software can load while frozen.
  always_ff @(posedge clock) begin
    if (reset) begin
      sh_int  <= DEF_INT;
      sh_frac <= DEF_FRAC;
    end else if (div_load) begin
      sh_int  <= ld_int;
      sh_frac <= div_frac;
    end
  end

  // Period counter, accumulator, phase and tick registers; resync outranks enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      cur_len  <= {1'b0, DEF_INT};
      acc      <= '0;
      os_phase <= '0;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else if (resync) begin
      // First period after resync carries nothing from the accumulator.
      cnt      <= '0;
      cur_len  <= {1'b0, nxt_int};
      acc      <= '0;
      os_phase <= '0;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else if (enable) begin
      if (at_end) begin
        cnt      <= '0;
        cur_len  <= nxt_len;
        acc      <= acc_sum;
        os_phase <= phase_inc;
        os_tick  <= 1'b1;
        mid_tick <= (phase_inc == MID_PHASE);
        bit_tick <= (phase_inc == '0);
      end else begin
        cnt      <= cnt + 1'b1;
        os_tick  <= 1'b0;
        mid_tick <= 1'b0;
        bit_tick <= 1'b0;
      end
    end else begin
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end
  end

endmodule
